// File: rtl/draw_pkg.sv
// Shared definitions for the line rasteriser: command op codes, FSM states
// and the linear framebuffer address mapping.
package draw_pkg;

  typedef enum logic [1:0] {
    OP_LINE  = 2'b00,
    OP_FILL  = 2'b01,
    OP_POINT = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LINE,
    S_FILL,
    S_POINT,
    S_DONE
  } state_e;

  function automatic int unsigned pix_addr(input int unsigned x, input int unsigned y,
                                           input int unsigned w);
    return x + y * w;
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham walker: holds the current pixel and error term, computes the
// next pixel combinationally and flags when the end point is reached.
module line_stepper #(
  parameter int P_CW = 11
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [P_CW-1:0] i_x0,
  input  logic [P_CW-1:0] i_y0,
  input  logic [P_CW-1:0] i_x1,
  input  logic [P_CW-1:0] i_y1,
  input  logic            i_step,
  output logic [P_CW-1:0] o_nx,
  output logic [P_CW-1:0] o_ny,
  output logic            o_last
);

  localparam int EW = P_CW + 2;

  logic [P_CW-1:0]       x, y, x1, y1;
  logic signed [EW-1:0]  err, dx, dy, err_n;
  logic signed [EW-1:0]  ddx, ddy, adx, ady;
  logic signed [EW:0]    e2, dx_w, dy_w;
  logic                  sx_neg, sy_neg, mv_x, mv_y;

  assign ddx = $signed({2'b00, i_x1}) - $signed({2'b00, i_x0});
  assign ddy = $signed({2'b00, i_y1}) - $signed({2'b00, i_y0});
  assign adx = ddx[EW-1] ? -ddx : ddx;
  assign ady = ddy[EW-1] ? -ddy : ddy;

  // Both moves are decided from the same pre-step e2.
  assign e2   = {err, 1'b0};
  assign dx_w = {dx[EW-1], dx};
  assign dy_w = {dy[EW-1], dy};
  assign mv_x = (e2 >= dy_w);
  assign mv_y = (e2 <= dx_w);

  assign o_nx   = mv_x ? (sx_neg ? x - P_CW'(1) : x + P_CW'(1)) : x;
  assign o_ny   = mv_y ? (sy_neg ? y - P_CW'(1) : y + P_CW'(1)) : y;
  assign err_n  = err + (mv_x ? dy : '0) + (mv_y ? dx : '0);
  assign o_last = (x == x1) && (y == y1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x      <= '0;
      y      <= '0;
      x1     <= '0;
      y1     <= '0;
      err    <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (i_load) begin
      x      <= i_x0;
      y      <= i_y0;
      x1     <= i_x1;
      y1     <= i_y1;
      dx     <= adx;
      dy     <= -ady;
      err    <= adx - ady;
      sx_neg <= ddx[EW-1];
      sy_neg <= ddy[EW-1];
    end else if (i_step) begin
      x   <= o_nx;
      y   <= o_ny;
      err <= err_n;
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Command-driven rasteriser: line, point and fill commands become pixel
// writes on a valid/ready framebuffer port, with clipping and backpressure.
//   state   | meaning
//   S_IDLE  | ready for a command
//   S_SETUP | load stepper from latched command, present first pixel
//   S_LINE  | walk Bresenham line, one pixel slot per advance
//   S_FILL  | walk addresses 0..W*H-1
//   S_POINT | single pixel slot
//   S_DONE  | one-cycle completion pulse
module line_raster_engine
  import draw_pkg::*;
#(
  parameter int P_X_COORD_W      = 11,
  parameter int P_Y_COORD_W      = 11,
  parameter int P_SCREEN_W       = 640,
  parameter int P_SCREEN_H       = 480,
  parameter int P_DATA_W         = 1,
  parameter int P_LOG2_RAM_DEPTH = 19
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [1:0]                  i_cmd_op,
  input  logic [P_X_COORD_W-1:0]      i_x0,
  input  logic [P_X_COORD_W-1:0]      i_x1,
  input  logic [P_Y_COORD_W-1:0]      i_y0,
  input  logic [P_Y_COORD_W-1:0]      i_y1,
  input  logic [P_DATA_W-1:0]         i_color,
  output logic                        o_wr_valid,
  input  logic                        i_wr_ready,
  output logic [P_LOG2_RAM_DEPTH-1:0] o_wr_addr,
  output logic [P_DATA_W-1:0]         o_wr_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [15:0]                 o_clip_cnt
);

  localparam int XY_W = (P_X_COORD_W > P_Y_COORD_W) ? P_X_COORD_W : P_Y_COORD_W;
  // Wide enough for fill to run as a horizontal line over the whole address range.
  localparam int CW   = (XY_W > P_LOG2_RAM_DEPTH) ? XY_W : P_LOG2_RAM_DEPTH;
  localparam logic [CW-1:0] FILL_END = CW'(P_SCREEN_W * P_SCREEN_H - 1);

  state_e          state, state_n;
  op_e             op_q;
  logic [CW-1:0]   cx0, cy0, cx1, cy1;
  logic [CW-1:0]   ld_x0, ld_y0, ld_x1, ld_y1, nx, ny;
  logic            is_fill, is_point, load, draw, adv, step, last;

  function automatic logic in_screen(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (32'(x) < 32'(P_SCREEN_W)) && (32'(y) < 32'(P_SCREEN_H));
  endfunction

  assign is_fill  = (op_q == OP_FILL);
  assign is_point = (op_q == OP_POINT);
  assign ld_x0    = is_fill ? '0 : cx0;
  assign ld_y0    = is_fill ? '0 : cy0;
  assign ld_x1    = is_fill ? FILL_END : (is_point ? cx0 : cx1);
  assign ld_y1    = is_fill ? '0 : (is_point ? cy0 : cy1);

  assign load = (state == S_SETUP);
  assign draw = (state == S_LINE) || (state == S_FILL) || (state == S_POINT);
  // A clipped slot has o_wr_valid low and always advances.
  assign adv  = draw && (!o_wr_valid || i_wr_ready);
  assign step = adv && !last;

  line_stepper #(.P_CW(CW)) u_stepper (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (load),
    .i_x0    (ld_x0),
    .i_y0    (ld_y0),
    .i_x1    (ld_x1),
    .i_y1    (ld_y1),
    .i_step  (step),
    .o_nx    (nx),
    .o_ny    (ny),
    .o_last  (last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) state_n = S_SETUP;
      end
      S_SETUP: begin
        case (op_q)
          OP_LINE:  state_n = S_LINE;
          OP_FILL:  state_n = S_FILL;
          OP_POINT: state_n = S_POINT;
          default:  state_n = S_DONE;
        endcase
      end
      S_LINE, S_FILL, S_POINT: begin
        if (adv && last) state_n = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q       <= OP_LINE;
      cx0        <= '0;
      cy0        <= '0;
      cx1        <= '0;
      cy1        <= '0;
      o_wr_data  <= '0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_clip_cnt <= '0;
    end else begin
      if (o_cmd_ready && i_cmd_valid) begin
        op_q       <= op_e'(i_cmd_op);
        cx0        <= CW'(i_x0);
        cy0        <= CW'(i_y0);
        cx1        <= CW'(i_x1);
        cy1        <= CW'(i_y1);
        o_wr_data  <= i_color;
        o_clip_cnt <= '0;
      end
      if (load && op_q != OP_RSVD) begin
        o_wr_valid <= is_fill || in_screen(ld_x0, ld_y0);
        o_wr_addr  <= P_LOG2_RAM_DEPTH'(pix_addr(32'(ld_x0), 32'(ld_y0), P_SCREEN_W));
      end
      if (adv) begin
        if (!o_wr_valid && o_clip_cnt != 16'hFFFF) o_clip_cnt <= o_clip_cnt + 16'd1;
        if (last) begin
          o_wr_valid <= 1'b0;
        end else begin
          o_wr_valid <= is_fill || in_screen(nx, ny);
          o_wr_addr  <= P_LOG2_RAM_DEPTH'(pix_addr(32'(nx), 32'(ny), P_SCREEN_W));
        end
      end
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Bench for line_raster_engine: table of directed commands, random lines
// against a Bresenham reference model, and small-screen fill/reset sequences.
module tb_line_raster_engine;
  import draw_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // Full-size instance
  logic        rst, cmd_valid, cmd_ready, wr_valid, wr_ready, busy, done;
  logic [1:0]  cmd_op;
  logic [10:0] x0, x1, y0, y1;
  logic [0:0]  color, wr_data;
  logic [18:0] wr_addr;
  logic [15:0] clip_cnt;

  line_raster_engine dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_x0(x0), .i_x1(x1), .i_y0(y0), .i_y1(y1), .i_color(color),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_clip_cnt(clip_cnt)
  );

  // 8x4 screen, 2-bit colour
  logic        s_rst, s_cmd_valid, s_cmd_ready, s_wr_valid, s_wr_ready, s_busy, s_done;
  logic [1:0]  s_cmd_op, s_color, s_wr_data;
  logic [10:0] s_x0, s_x1, s_y0, s_y1;
  logic [4:0]  s_wr_addr;
  logic [15:0] s_clip_cnt;

  line_raster_engine #(
    .P_X_COORD_W(11), .P_Y_COORD_W(11), .P_SCREEN_W(8), .P_SCREEN_H(4),
    .P_DATA_W(2), .P_LOG2_RAM_DEPTH(5)
  ) dut_s (
    .i_clk(clk), .i_reset(s_rst), .i_cmd_valid(s_cmd_valid), .o_cmd_ready(s_cmd_ready),
    .i_cmd_op(s_cmd_op), .i_x0(s_x0), .i_x1(s_x1), .i_y0(s_y0), .i_y1(s_y1), .i_color(s_color),
    .o_wr_valid(s_wr_valid), .i_wr_ready(s_wr_ready), .o_wr_addr(s_wr_addr),
    .o_wr_data(s_wr_data), .o_busy(s_busy), .o_done(s_done), .o_clip_cnt(s_clip_cnt)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Write monitors
  int got_a[$], got_d[$], s_got_a[$], s_got_d[$];
  int first_cyc, done_cnt, done_cyc, s_done_cnt;
  bit prev_stall = 1'b0;
  int prev_addr, prev_data;

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_valid_held", int'(wr_valid), 1);
      chk("stall_addr_held", int'(wr_addr), prev_addr);
      chk("stall_data_held", int'(wr_data), prev_data);
    end
    prev_stall = wr_valid && !wr_ready;
    prev_addr  = int'(wr_addr);
    prev_data  = int'(wr_data);
    if (wr_valid && wr_ready) begin
      if (got_a.size() == 0) first_cyc = cyc;
      got_a.push_back(int'(wr_addr));
      got_d.push_back(int'(wr_data));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_wr_valid && s_wr_ready) begin
      s_got_a.push_back(int'(s_wr_addr));
      s_got_d.push_back(int'(s_wr_data));
    end
    if (s_done) s_done_cnt++;
  end

  // Reference: plain integer Bresenham on a 640x480 screen
  int exp_a[$];
  int exp_clip;
  bit exp_first_in;

  task automatic model(input int op, input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_a.delete();
    exp_clip = 0;
    exp_first_in = 1'b0;
    if (op == 3) return;
    if (op == 2) begin ax1 = ax0; ay1 = ay0; end
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    exp_first_in = (x < 640) && (y < 480);
    forever begin
      if (x < 640 && y < 480) exp_a.push_back(y * 640 + x);
      else exp_clip++;
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic run(input int op, input int ax0, input int ay0, input int ax1, input int ay1,
                     input int ic, input bit rnd, output int nwr);
    int acc, n;
    got_a.delete();
    got_d.delete();
    done_cnt = 0;
    model(op, ax0, ay0, ax1, ay1);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op = 2'(op);
    x0 = 11'(ax0); y0 = 11'(ay0); x1 = 11'(ax1); y1 = 11'(ay1);
    color = 1'(ic);
    wr_ready = 1'b1;
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    acc = cyc;
    @(posedge clk); #1;
    // Scramble inputs after accept; the engine must ignore them.
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    x0 = 11'($urandom); y0 = 11'($urandom); x1 = 11'($urandom); y1 = 11'($urandom);
    color = ~color;
    chk("busy_setup", int'(busy), 1);
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("cmd_ready_after_done", int'(cmd_ready), 1);
      chk("busy_after_done", int'(busy), 0);
    end
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("wr_count", got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk("wr_addr", got_a[i], exp_a[i]);
      chk("wr_data", got_d[i], ic);
    end
    chk("clip_cnt", int'(clip_cnt), exp_clip);
    if (!rnd) begin
      chk("done_cycle", done_cyc, acc + 2 + exp_a.size() + exp_clip);
      if (exp_first_in && got_a.size() > 0) chk("first_write_latency", first_cyc, acc + 2);
    end
    nwr = got_a.size();
  endtask

  typedef struct {
    int op, x0, y0, x1, y1, c;
    bit rnd;
    int n, first, last, clip;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nwr, n, ax0, ay0, ax1, ay1, op, dxa, dya;
    bit rnd;

    tbl[0] = '{0,   0,   0,   3,   0, 1, 1'b0, 4,      0,      3, 0};
    tbl[1] = '{0,   0,   0,   2,   5, 1, 1'b0, 6,      0,   3202, 0};
    tbl[2] = '{0,   3,   2,   0,   2, 1, 1'b0, 4,   1283,   1280, 0};
    tbl[3] = '{0,   0,   0,   7,   7, 1, 1'b1, 8,      0,   4487, 0};
    tbl[4] = '{0, 638,   0, 641,   0, 1, 1'b0, 2,    638,    639, 2};
    tbl[5] = '{2,   5,   3,   0,   0, 1, 1'b0, 1,   1925,   1925, 0};
    tbl[6] = '{2, 700,   3,   0,   0, 0, 1'b0, 0,      0,      0, 1};
    tbl[7] = '{3,  10,  10,  20,  20, 1, 1'b0, 0,      0,      0, 0};
    tbl[8] = '{0, 639, 479, 636, 475, 0, 1'b1, 5, 307199, 304636, 0};

    rst = 1'b1; s_rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0; wr_ready = 1'b1;
    s_cmd_valid = 1'b0; s_cmd_op = '0; s_x0 = '0; s_x1 = '0; s_y0 = '0; s_y1 = '0;
    s_color = '0; s_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; s_rst = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_clip_cnt", int'(clip_cnt), 0);

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, tbl[i].rnd, nwr);
      chk("tbl_count", nwr, tbl[i].n);
      if (tbl[i].n > 0 && nwr > 0) begin
        chk("tbl_first_addr", got_a[0], tbl[i].first);
        chk("tbl_last_addr", got_a[nwr-1], tbl[i].last);
      end
      chk("tbl_clip", int'(clip_cnt), tbl[i].clip);
    end

    for (int k = 0; k < 16; k++) begin
      ax0 = int'($urandom_range(0, 700));
      ay0 = int'($urandom_range(0, 520));
      ax1 = ax0 + int'($urandom_range(0, 80)) - 40;
      ay1 = ay0 + int'($urandom_range(0, 80)) - 40;
      if (ax1 < 0) ax1 = 0;
      if (ay1 < 0) ay1 = 0;
      op  = ($urandom_range(0, 7) == 0) ? 2 : 0;
      rnd = 1'($urandom_range(0, 1));
      run(op, ax0, ay0, ax1, ay1, int'($urandom_range(0, 1)), rnd, nwr);
      if (op == 0) begin
        dxa = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dya = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        chk("rand_pixel_total", nwr + int'(clip_cnt), ((dxa > dya) ? dxa : dya) + 1);
      end
    end

    // Fill on the 8x4 screen
    s_got_a.delete(); s_got_d.delete(); s_done_cnt = 0;
    @(posedge clk); #1;
    s_cmd_valid = 1'b1; s_cmd_op = OP_FILL; s_color = 2'd3;
    chk("fill_cmd_ready", int'(s_cmd_ready), 1);
    @(posedge clk); #1;
    s_cmd_valid = 1'b0; s_color = 2'd1;
    n = 0;
    while (s_done_cnt == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fill_done_seen", s_done_cnt, 1);
    chk("fill_count", s_got_a.size(), 32);
    for (int i = 0; i < s_got_a.size() && i < 32; i++) begin
      chk("fill_addr", s_got_a[i], i);
      chk("fill_data", s_got_d[i], 3);
    end
    chk("fill_clip", int'(s_clip_cnt), 0);

    // Fill aborted by reset while address 10 is presented
    repeat (2) @(posedge clk);
    #1;
    s_got_a.delete(); s_got_d.delete(); s_done_cnt = 0;
    s_cmd_valid = 1'b1; s_cmd_op = OP_FILL; s_color = 2'd2;
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    n = 0;
    while (!(s_wr_valid && s_wr_addr == 5'd10) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_addr10", int'(s_wr_valid && s_wr_addr == 5'd10), 1);
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    chk("abort_wr_valid", int'(s_wr_valid), 0);
    chk("abort_cmd_ready", int'(s_cmd_ready), 1);
    chk("abort_busy", int'(s_busy), 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", s_done_cnt, 0);
    chk("abort_write_count", s_got_a.size(), 11);
    chk("abort_still_idle", int'(s_cmd_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
